// File: rtl/sr_bist_pkg.sv
// Shared definitions for the SR flip-flop BIST: FSM states, step indices and
// the per-step drive/expect table, each table bit-indexed by step number.
package sr_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam logic [2:0] STEP_INIT  = 3'd0;
    localparam logic [2:0] STEP_HOLD0 = 3'd1;
    localparam logic [2:0] STEP_SET   = 3'd2;
    localparam logic [2:0] STEP_HOLD1 = 3'd3;
    localparam logic [2:0] STEP_RESET = 3'd4;
    localparam logic [2:0] STEP_BOTH  = 3'd5;
    localparam logic [2:0] STEP_CLEAR = 3'd6;
    localparam logic [2:0] NO_FAIL    = 3'd7;

    // Bit 7 is padding so a 3-bit step index never selects outside the table.
    localparam logic [7:0] STEP_S       = 8'b0010_0100;
    localparam logic [7:0] STEP_R       = 8'b0111_0001;
    localparam logic [7:0] STEP_EXP     = 8'b0000_1100;
    localparam logic [7:0] STEP_CHECKED = 8'b0101_1111;

endpackage

// File: rtl/sr_bist_hold_counter.sv
// Modulo-HOLD_CYCLES step timer; tc flags the last cycle of each step.
module hold_counter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count_q;

    assign tc = en && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tc ? '0 : count_q + CW'(1);
        end
    end

endmodule

// File: rtl/sr_bist.sv
// Drives an SR flip-flop through a fixed seven-step pattern, samples q at the
// end of each step and reports pass, first failing step and mismatch count.
module sr_bist
    import sr_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter bit CHECK_BOTH  = 1'b0,
    parameter bit EXP_BOTH    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       q_in,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_step,
    output logic [2:0] err_count
);

    state_e     state_q;
    logic [2:0] step_q;
    logic       s_q;
    logic       r_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] failStep_q;
    logic [2:0] errCount_q;

    logic [2:0] failStep_d;
    logic [2:0] errCount_d;
    logic [2:0] nextStep;
    logic       stepTc;
    logic       stepChecked;
    logic       stepExp;
    logic       mismatch;

    hold_counter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk(clk),
        .rst(rst),
        .clr(state_q != ST_RUN),
        .en (state_q == ST_RUN),
        .tc (stepTc)
    );

    // Score the current step on its last cycle; the BOTH step is configurable.
    always_comb begin
        stepChecked = STEP_CHECKED[step_q];
        stepExp     = STEP_EXP[step_q];
        if (step_q == STEP_BOTH) begin
            stepChecked = CHECK_BOTH;
            stepExp     = EXP_BOTH;
        end
        mismatch   = stepTc && stepChecked && (q_in != stepExp);
        nextStep   = step_q + 3'd1;
        errCount_d = errCount_q;
        failStep_d = failStep_q;
        if (mismatch) begin
            if (errCount_q != 3'd7) begin
                errCount_d = errCount_q + 3'd1;
            end
            if (failStep_q == NO_FAIL) begin
                failStep_d = step_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= STEP_INIT;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            failStep_q <= NO_FAIL;
            errCount_q <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        step_q     <= STEP_INIT;
                        s_q        <= STEP_S[STEP_INIT];
                        r_q        <= STEP_R[STEP_INIT];
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        failStep_q <= NO_FAIL;
                        errCount_q <= 3'd0;
                    end
                end
                ST_RUN: begin
                    errCount_q <= errCount_d;
                    failStep_q <= failStep_d;
                    if (stepTc) begin
                        if (step_q == STEP_CLEAR) begin
                            // pass uses the score including the final step's compare.
                            state_q <= ST_FINISH;
                            s_q     <= 1'b0;
                            r_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (errCount_d == 3'd0);
                        end else begin
                            step_q <= nextStep;
                            s_q    <= STEP_S[nextStep];
                            r_q    <= STEP_R[nextStep];
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    step_q  <= STEP_INIT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s         = s_q;
    assign r         = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_step = failStep_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_sr_bist.sv
// Bench for sr_bist: two instances (BOTH step unchecked / checked against 1)
// watching a behavioural SR flip-flop or tied/random q sources.
module tb_sr_bist;

    localparam int HOLD    = 4;
    localparam int RUN_LEN = 7 * HOLD;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic rndQ  = 1'b0;
    logic srQ   = 1'b0;
    logic qIn;
    int   qMode = 0;

    logic       s, r, busy, done, pass;
    logic [2:0] failStep, errCount;
    logic       s2, r2, busy2, done2, pass2;
    logic [2:0] failStep2, errCount2;

    int checkCount = 0;
    int passCount  = 0;

    int sTab[7]   = '{0, 0, 1, 0, 0, 1, 0};
    int rTab[7]   = '{1, 0, 0, 0, 1, 1, 1};
    int expTab[7] = '{0, 0, 1, 1, 0, 0, 0};

    always #5 clk = ~clk;

    // Reference SR flip-flop: reset dominates when both inputs are high.
    always @(posedge clk) begin
        if (r) srQ <= 1'b0;
        else if (s) srQ <= 1'b1;
    end

    assign qIn = (qMode == 0) ? srQ : (qMode == 1) ? 1'b0 : (qMode == 2) ? 1'b1 : rndQ;

    sr_bist #(.HOLD_CYCLES(HOLD), .CHECK_BOTH(1'b0), .EXP_BOTH(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .q_in(qIn),
        .s(s), .r(r), .busy(busy), .done(done), .pass(pass),
        .fail_step(failStep), .err_count(errCount)
    );

    sr_bist #(.HOLD_CYCLES(HOLD), .CHECK_BOTH(1'b1), .EXP_BOTH(1'b1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .q_in(qIn),
        .s(s2), .r(r2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_step(failStep2), .err_count(errCount2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Expected verdict from the q value seen on the last cycle of each step.
    function automatic void scoreRun(input logic [RUN_LEN-1:0] hist, input bit chkBoth, input bit expBoth,
                                     output bit expPass, output logic [2:0] expFail, output logic [2:0] expErr);
        int misses;
        bit checked;
        bit expQ;
        misses  = 0;
        expFail = 3'd7;
        for (int k = 0; k < 7; k++) begin
            checked = (k == 5) ? chkBoth : 1'b1;
            expQ    = (k == 5) ? expBoth : expTab[k][0];
            if (checked && (hist[(k + 1) * HOLD - 1] != expQ)) begin
                misses++;
                if (expFail == 3'd7) expFail = 3'(k);
            end
        end
        expErr  = (misses > 7) ? 3'd7 : 3'(misses);
        expPass = (misses == 0);
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, ".s"}, 32'(s), 0);
        checkOutput({tag, ".r"}, 32'(r), 0);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".done"}, 32'(done), 0);
        checkOutput({tag, ".pass"}, 32'(pass), 0);
        checkOutput({tag, ".failStep"}, 32'(failStep), 7);
        checkOutput({tag, ".errCount"}, 32'(errCount), 0);
        checkOutput({tag, ".busy2"}, 32'(busy2), 0);
        checkOutput({tag, ".failStep2"}, 32'(failStep2), 7);
        checkOutput({tag, ".errCount2"}, 32'(errCount2), 0);
    endtask

    // One run from an idle DUT; midStart/rstAt are cycle offsets (-1 = none).
    task automatic applyStimulus(input int qModeSel, input int midStart, input int rstAt, input bit startInDone);
        logic [RUN_LEN-1:0] hist;
        bit                 p1, p2;
        logic [2:0]         f1, e1, f2, e2;
        bit                 sawDone;
        int                 k;
        hist  = '0;
        qMode = qModeSel;
        rndQ  = 1'($urandom);
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= RUN_LEN + 1; c++) begin
            start = 1'b0;
            if (qMode == 3) rndQ = 1'($urandom);
            #1;
            if (c < RUN_LEN) begin
                k = c / HOLD;
                checkOutput("busy", 32'(busy), 1);
                checkOutput("busy2", 32'(busy2), 1);
                checkOutput("s", 32'(s), 32'(sTab[k]));
                checkOutput("r", 32'(r), 32'(rTab[k]));
                checkOutput("s2", 32'(s2), 32'(sTab[k]));
                checkOutput("done", 32'(done), 0);
                if (c == 0) begin
                    checkOutput("passCleared", 32'(pass), 0);
                    checkOutput("failCleared", 32'(failStep), 7);
                    checkOutput("errCleared", 32'(errCount), 0);
                end
                hist[c] = qIn;
                if (c == midStart) start = 1'b1;
                if (c == rstAt) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst   = 1'b0;
                    start = 1'b0;
                    checkReset("midRst");
                    sawDone = 1'b0;
                    repeat (RUN_LEN + 4) begin
                        @(negedge clk);
                        sawDone = sawDone | done | done2;
                    end
                    checkOutput("noDoneAfterRst", 32'(sawDone), 0);
                    return;
                end
            end else if (c == RUN_LEN) begin
                checkOutput("done", 32'(done), 1);
                checkOutput("done2", 32'(done2), 1);
                checkOutput("busyFall", 32'(busy), 0);
                checkOutput("sEnd", 32'(s), 0);
                checkOutput("rEnd", 32'(r), 0);
                start = startInDone;
            end else begin
                scoreRun(hist, 1'b0, 1'b0, p1, f1, e1);
                scoreRun(hist, 1'b1, 1'b1, p2, f2, e2);
                checkOutput("donePulse", 32'(done), 0);
                checkOutput("idleAfterDone", 32'(busy), 0);
                checkOutput("pass", 32'(pass), 32'(p1));
                checkOutput("failStep", 32'(failStep), 32'(f1));
                checkOutput("errCount", 32'(errCount), 32'(e1));
                checkOutput("pass2", 32'(pass2), 32'(p2));
                checkOutput("failStep2", 32'(failStep2), 32'(f2));
                checkOutput("errCount2", 32'(errCount2), 32'(e2));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed runs");
        applyStimulus(0, -1, -1, 1'b0);
        checkOutput("goodPass", 32'(pass), 1);
        checkOutput("goodBothFail", 32'(failStep2), 5);
        applyStimulus(1, -1, -1, 1'b0);
        checkOutput("tie0Fail", 32'(failStep), 2);
        checkOutput("tie0Err", 32'(errCount), 2);
        applyStimulus(2, -1, -1, 1'b0);
        checkOutput("tie1Fail", 32'(failStep), 0);
        checkOutput("tie1Err", 32'(errCount), 4);
        applyStimulus(0, 3 * HOLD + 1, -1, 1'b1);
        applyStimulus(0, -1, 4 * HOLD + 2, 1'b0);
        applyStimulus(0, -1, -1, 1'b0);

        $display("[TB] randomized runs");
        for (int i = 0; i < 12; i++) begin
            applyStimulus($urandom_range(0, 3),
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, RUN_LEN - 1)) : -1,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, RUN_LEN - 1)) : -1,
                          1'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
